// File: rtl/serial_pkg.sv
// Shared serial link constants: receiver FSM state encoding
// and the parity sense values used by both link ends.
package serial_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DATA      = 3'd1;
    localparam logic [2:0] ST_PARITY    = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// One-bit XOR accumulator; clr wins over en.
// Shared by the receiver (check) and transmitter (generate).
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    // fold each enabled bit into the running XOR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, LSB-first data, parity, stop.
// Reports data with parity and framing status as a 1-clk valid.
module serial_parity_rx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import serial_pkg::*;

    localparam int CW = $clog2(DATA_BITS + 1);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;
    logic                 perr;
    logic                 acc_clr;
    logic                 acc_en;

    assign acc_clr = tick && (state == ST_IDLE);
    assign acc_en  = tick && (state == ST_DATA);
    assign busy    = (state != ST_IDLE);

    parity_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (rx),
        .acc   (acc)
    );

    // frame FSM, bit counter and shift register advance on ticks only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            perr  <= 1'b0;
        end else if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state <= ST_DATA;
                        cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    shreg <= DATA_BITS'({rx, shreg} >> 1);
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DATA_BITS - 1)) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr  <= acc ^ rx ^ PARITY_ODD;
                    state <= ST_STOP;
                end
                ST_STOP: begin
                    state <= rx ? ST_IDLE : ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (rx) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // publish the frame result in the clk after the stop tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick && (state == ST_STOP)) begin
                data       <= shreg;
                parity_err <= perr;
                frame_err  <= ~rx;
                valid      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Testbench for serial_parity_rx: table vectors, corner sequences
// and random-gap frames against a frame-level reference model.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, busy0, busy1;
    logic       noise = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } cap_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
        logic       epo;
    } vec_t;

    cap_t q0[$];
    cap_t q1[$];
    vec_t tbl[6];

    serial_parity_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
        .data(data0), .valid(v0), .parity_err(pe0),
        .frame_err(fe0), .busy(busy0)
    );

    serial_parity_rx #(.DATA_BITS(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
        .data(data1), .valid(v1), .parity_err(pe1),
        .frame_err(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) q0.push_back('{data0, pe0, fe0, cyc});
        if (v1) q1.push_back('{data1, pe1, fe1, cyc});
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        rx   = b;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int k = 1; k < gap; k++) begin
            if (noise) rx = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, gap);
    endtask

    task automatic settle();
        noise = 1'b0;
        send_bit(1'b1, 4);
        repeat (3) @(negedge clk);
    endtask

    // frame-level reference: parity counted over the whole frame
    function automatic logic model_pe(input logic [7:0] d, input logic p,
                                      input logic odd);
        int ones;
        ones = $countones(d) + int'(p);
        return ((ones % 2) == 1) != odd;
    endfunction

    task automatic chk_one(input string nm, input logic [7:0] ed,
                           input logic epe, input logic efe, input logic epo);
        cap_t c;
        chk({nm, "_cnt"}, q0.size(), 1);
        chk({nm, "_cnt_odd"}, q1.size(), 1);
        if (q0.size() > 0) begin
            c = q0.pop_front();
            chk({nm, "_data"}, c.d, ed);
            chk({nm, "_perr"}, c.pe, epe);
            chk({nm, "_ferr"}, c.fe, efe);
        end
        if (q1.size() > 0) begin
            c = q1.pop_front();
            chk({nm, "_data_odd"}, c.d, ed);
            chk({nm, "_perr_odd"}, c.pe, epo);
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        cap_t a, b;
        logic [7:0] rd;
        logic       rp, rs;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_data", data0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_perr", pe0, 0);
        chk("rst_ferr", fe0, 0);
        chk("rst_busy", busy0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // case 1: latency and busy on a clean frame
        send_bit(1'b0, 1);
        chk("c1_busy_start", busy0, 1);
        for (int i = 0; i < 8; i++) send_bit(rx ^ rx | tbl[0].d[i], 1);
        send_bit(1'b0, 1);
        rx   = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("c1_valid_lat", v0, 1);
        chk("c1_data_lat", data0, 8'hA5);
        @(negedge clk);
        chk("c1_valid_pulse", v0, 0);
        chk("c1_busy_end", busy0, 0);
        repeat (2) @(negedge clk);
        chk_one("c1", 8'hA5, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 4);
            settle();
            chk_one($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].epe,
                    tbl[i].efe, tbl[i].epo);
        end

        // case 3: break after a bad stop bit gives one frame only
        send_frame(8'h3C, 1'b0, 1'b0, 4);
        for (int i = 0; i < 20; i++) send_bit(1'b0, 4);
        chk("c3_busy_break", busy0, 1);
        send_bit(1'b1, 4);
        chk("c3_busy_idle", busy0, 0);
        repeat (3) @(negedge clk);
        chk_one("c3", 8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        settle();
        chk_one("c3_next", 8'h5A, 1'b0, 1'b0, 1'b1);

        // case 4: reset in the middle of a frame
        send_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 4);
        chk("c4_busy_pre", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("c4_data", data0, 0);
        chk("c4_busy", busy0, 0);
        chk("c4_valid", v0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("c4_no_valid", q0.size(), 0);
        q1.delete();
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        settle();
        chk_one("c4_next", 8'h5A, 1'b0, 1'b0, 1'b1);

        // case 5: back-to-back frames, tick every clk
        send_frame(8'h12, 1'b0, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1'b1, 1);
        settle();
        chk("c5_cnt", q0.size(), 2);
        if (q0.size() == 2) begin
            a = q0.pop_front();
            b = q0.pop_front();
            chk("c5_data0", a.d, 8'h12);
            chk("c5_data1", b.d, 8'h34);
            chk("c5_err", {a.pe, a.fe, b.pe, b.fe}, 0);
            chk("c5_gap", b.c - a.c, 11);
        end
        q0.delete();
        q1.delete();

        // case 6: random tick gaps and line noise between ticks
        for (int t = 0; t < 12; t++) begin
            rd = (t == 0) ? 8'hA5 : 8'($urandom);
            rp = (t == 0) ? 1'b0 : 1'($urandom);
            rs = (t == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            noise = 1'b1;
            send_bit(1'b0, $urandom_range(1, 7));
            for (int i = 0; i < 8; i++) send_bit(rd[i], $urandom_range(1, 7));
            send_bit(rp, $urandom_range(1, 7));
            send_bit(rs, $urandom_range(1, 7));
            settle();
            chk_one($sformatf("rnd%0d", t), rd, model_pe(rd, rp, 1'b0),
                    ~rs, model_pe(rd, rp, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
